// File: rtl/sha256_id_alloc.sv
// ---------------------------------------------------------------------------
// sha256_id_alloc
//   Issues sequential IDs to the SHA-2 message path. Each ID is broadcast to
//   NUM_CH consumers, each with its own valid/ready handshake; the ID advances
//   only once every channel has taken it. Issued-but-not-retired IDs are
//   counted and issue stalls at MAX_OUTSTANDING. Retirements must come back
//   oldest-first; any other ID raises a sticky error flag.
//
// Ports
//   clk              clock, all logic on posedge
//   nrst             asynchronous active-low reset
//   en               issue enable
//   sync_rst         synchronous reset, same effect as nrst, highest priority
//   id_out           current ID shared by all channels
//   id_out_last      id_out is the all-ones wrap point while any valid is high
//   id_out_valid     per-channel valid
//   id_out_ready     per-channel ready
//   id_retire        ID being retired
//   id_retire_valid  retire valid
//   id_retire_ready  retire ready (something is outstanding)
//   outstanding      issued-not-retired count
//   retire_err       sticky out-of-order retire flag
// ---------------------------------------------------------------------------
module sha256_id_alloc #(
  parameter int ID_W            = 6,
  parameter int NUM_CH          = 2,
  parameter int MAX_OUTSTANDING = 16,
  localparam int CNT_W          = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              en,
  input  logic              sync_rst,
  output logic [ID_W-1:0]   id_out,
  output logic              id_out_last,
  output logic [NUM_CH-1:0] id_out_valid,
  input  logic [NUM_CH-1:0] id_out_ready,
  input  logic [ID_W-1:0]   id_retire,
  input  logic              id_retire_valid,
  output logic              id_retire_ready,
  output logic [CNT_W-1:0]  outstanding,
  output logic              retire_err
);

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUTSTANDING);

  typedef enum logic {S_IDLE, S_ISSUE} state_t;

  state_t            r_state;
  state_t            w_state_next;
  logic [ID_W-1:0]   r_id;
  logic [NUM_CH-1:0] r_accepted;
  logic [CNT_W-1:0]  r_outstanding;
  logic              r_err;

  logic [NUM_CH-1:0] w_valid;
  logic [NUM_CH-1:0] w_hs;
  logic              w_complete;
  logic              w_retire_ready;
  logic              w_retire;
  logic [ID_W-1:0]   w_expected;
  logic [CNT_W-1:0]  w_out_next;
  logic              w_can_issue;

  // A channel that already took the current ID drops its valid until every
  // other channel has caught up.
  always_comb begin
    w_valid = '0;
    if (r_state == S_ISSUE) begin
      w_valid = ~r_accepted;
    end
  end

  assign w_hs           = w_valid & id_out_ready;
  assign w_complete     = (r_state == S_ISSUE) && (&(r_accepted | w_hs));
  assign w_retire_ready = (r_outstanding != '0);
  assign w_retire       = id_retire_valid && w_retire_ready;

  // r_id is the next ID to complete, so the oldest outstanding ID sits
  // r_outstanding places behind it (modulo the ID space).
  assign w_expected = r_id - ID_W'(r_outstanding);

  // Simultaneous issue and retire cancel out.
  always_comb begin
    w_out_next = r_outstanding;
    if (w_complete && !w_retire) begin
      w_out_next = r_outstanding + CNT_W'(1);
    end else if (!w_complete && w_retire) begin
      w_out_next = r_outstanding - CNT_W'(1);
    end
  end

  // Room is judged on the post-update count so a retire that frees a slot
  // lets valids reassert on the very next cycle.
  assign w_can_issue = en && (w_out_next < MAX_CNT);

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (w_can_issue) w_state_next = S_ISSUE;
      S_ISSUE: if (w_complete && !w_can_issue) w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_state       <= S_IDLE;
      r_id          <= '0;
      r_accepted    <= '0;
      r_outstanding <= '0;
      r_err         <= 1'b0;
    end else if (sync_rst) begin
      r_state       <= S_IDLE;
      r_id          <= '0;
      r_accepted    <= '0;
      r_outstanding <= '0;
      r_err         <= 1'b0;
    end else begin
      r_state       <= w_state_next;
      r_outstanding <= w_out_next;
      if (w_complete) begin
        r_id       <= r_id + ID_W'(1);
        r_accepted <= '0;
      end else begin
        r_accepted <= r_accepted | w_hs;
      end
      if (w_retire && (id_retire != w_expected)) begin
        r_err <= 1'b1;
      end
    end
  end

  assign id_out          = r_id;
  assign id_out_valid    = w_valid;
  assign id_out_last     = (r_id == {ID_W{1'b1}}) && (|w_valid);
  assign id_retire_ready = w_retire_ready;
  assign outstanding     = r_outstanding;
  assign retire_err      = r_err;

endmodule

// File: tb/tb_sha256_id_alloc.sv
// ---------------------------------------------------------------------------
// tb_sha256_id_alloc
//   Self-checking bench for sha256_id_alloc with default parameters
//   (ID_W=6, NUM_CH=2, MAX_OUTSTANDING=16). A negedge monitor keeps a
//   transaction-level model: the list of IDs each channel received, how many
//   IDs are fully issued and retired, and the expected error flag.
// ---------------------------------------------------------------------------
module tb_sha256_id_alloc;

  localparam int MAXO = 16;

  logic       clk = 1'b0;
  logic       nrst = 1'b0;
  logic       en = 1'b0;
  logic       sync_rst = 1'b0;
  logic [5:0] id_out;
  logic       id_out_last;
  logic [1:0] id_out_valid;
  logic [1:0] id_out_ready = 2'b00;
  logic [5:0] id_retire = 6'd0;
  logic       id_retire_valid = 1'b0;
  logic       id_retire_ready;
  logic [4:0] outstanding;
  logic       retire_err;

  sha256_id_alloc dut (
    .clk(clk), .nrst(nrst), .en(en), .sync_rst(sync_rst),
    .id_out(id_out), .id_out_last(id_out_last),
    .id_out_valid(id_out_valid), .id_out_ready(id_out_ready),
    .id_retire(id_retire), .id_retire_valid(id_retire_valid),
    .id_retire_ready(id_retire_ready),
    .outstanding(outstanding), .retire_err(retire_err)
  );

  always #5 clk = ~clk;

  int nChecks = 0;
  int nPass = 0;

  // Reference model state
  logic [5:0] seq0[$];
  logic [5:0] seq1[$];
  int issuedCnt = 0;
  int retiredCnt = 0;
  logic mErr = 1'b0;
  int lastViol = 0;
  int throttleViol = 0;
  int readyViol = 0;
  int sawLast = 0;

  // Inputs only change just after posedge, so what is seen here is exactly
  // what the next posedge will act on.
  always @(negedge clk) begin
    if (nrst && !sync_rst) begin
      if (id_out_last !== ((id_out == 6'h3f) && (id_out_valid != 2'b00))) lastViol++;
      if (id_out_last === 1'b1) sawLast++;
      if ((id_out_valid != 2'b00) && (issuedCnt - retiredCnt == MAXO)) throttleViol++;
      if (id_retire_ready !== (issuedCnt != retiredCnt)) readyViol++;
      if (id_out_valid[0] && id_out_ready[0]) seq0.push_back(id_out);
      if (id_out_valid[1] && id_out_ready[1]) seq1.push_back(id_out);
      if (id_retire_valid && id_retire_ready) begin
        if (id_retire != 6'(retiredCnt)) mErr = 1'b1;
        retiredCnt++;
      end
      issuedCnt = (seq0.size() < seq1.size()) ? seq0.size() : seq1.size();
    end
  end

  task automatic clearModel();
    seq0.delete();
    seq1.delete();
    issuedCnt = 0;
    retiredCnt = 0;
    mErr = 1'b0;
    lastViol = 0;
    throttleViol = 0;
    readyViol = 0;
    sawLast = 0;
  endtask

  task automatic doReset();
    en = 1'b0;
    id_out_ready = 2'b00;
    id_retire_valid = 1'b0;
    id_retire = 6'd0;
    sync_rst = 1'b0;
    nrst = 1'b0;
    repeat (2) @(posedge clk);
    #1 nrst = 1'b1;
    clearModel();
  endtask

  task automatic test_reset();
    doReset();
    #1;
    nChecks++; if (id_out !== 6'd0) $display("[TB] FAIL reset_id: got %0d want 0", id_out); else nPass++;
    nChecks++; if (id_out_valid !== 2'b00) $display("[TB] FAIL reset_valid: got %b want 00", id_out_valid); else nPass++;
    nChecks++; if (id_out_last !== 1'b0) $display("[TB] FAIL reset_last: got %b want 0", id_out_last); else nPass++;
    nChecks++; if (outstanding !== 5'd0) $display("[TB] FAIL reset_outstanding: got %0d want 0", outstanding); else nPass++;
    nChecks++; if (retire_err !== 1'b0) $display("[TB] FAIL reset_err: got %b want 0", retire_err); else nPass++;
    nChecks++; if (id_retire_ready !== 1'b0) $display("[TB] FAIL reset_retire_ready: got %b want 0", id_retire_ready); else nPass++;
  endtask

  // Both ready, no retires: 16 IDs back to back, then throttled.
  task automatic test_full_rate();
    int bad;
    doReset();
    en = 1'b1;
    id_out_ready = 2'b11;
    repeat (17) @(posedge clk);
    #1;
    nChecks++; if (seq0.size() != 16 || seq1.size() != 16) $display("[TB] FAIL full_rate_count: got %0d/%0d want 16/16", seq0.size(), seq1.size()); else nPass++;
    bad = 0;
    for (int i = 0; i < seq0.size() && i < seq1.size(); i++)
      if (seq0[i] != 6'(i) || seq1[i] != 6'(i)) bad++;
    nChecks++; if (bad != 0) $display("[TB] FAIL full_rate_seq: got %0d wrong IDs want 0", bad); else nPass++;
    repeat (3) @(posedge clk);
    #1;
    nChecks++; if (int'(outstanding) != MAXO) $display("[TB] FAIL full_rate_outstanding: got %0d want %0d", outstanding, MAXO); else nPass++;
    nChecks++; if (id_out_valid !== 2'b00) $display("[TB] FAIL full_rate_throttle_valid: got %b want 00", id_out_valid); else nPass++;
    nChecks++; if (id_out !== 6'd16) $display("[TB] FAIL full_rate_next_id: got %0d want 16", id_out); else nPass++;
    nChecks++; if (throttleViol != 0) $display("[TB] FAIL full_rate_throttle_viol: got %0d want 0", throttleViol); else nPass++;
  endtask

  // ch1 waits three cycles of valid before taking each ID.
  task automatic test_slow_channel();
    int wait1;
    int bad;
    doReset();
    en = 1'b1;
    id_out_ready = 2'b01;
    wait1 = 0;
    for (int cyc = 0; cyc < 60; cyc++) begin
      @(posedge clk);
      #1;
      if (seq0.size() > seq1.size()) begin
        nChecks++; if (id_out_valid !== 2'b10) $display("[TB] FAIL slow_valid_split: got %b want 10", id_out_valid); else nPass++;
        nChecks++; if (id_out !== seq0[seq0.size()-1]) $display("[TB] FAIL slow_id_held: got %0d want %0d", id_out, seq0[seq0.size()-1]); else nPass++;
      end
      nChecks++;
      if (seq0.size() < seq1.size() || seq0.size() > seq1.size() + 1)
        $display("[TB] FAIL slow_lead: got ch0=%0d ch1=%0d want lead 0..1", seq0.size(), seq1.size());
      else nPass++;
      if (id_out_ready[1]) wait1 = 0;
      else if (id_out_valid[1]) wait1++;
      id_out_ready[1] = (wait1 >= 3);
    end
    bad = 0;
    for (int i = 0; i < seq1.size(); i++)
      if (seq0[i] != seq1[i] || seq1[i] != 6'(i)) bad++;
    nChecks++; if (bad != 0) $display("[TB] FAIL slow_seq_match: got %0d wrong IDs want 0", bad); else nPass++;
    nChecks++; if (seq1.size() < 10) $display("[TB] FAIL slow_progress: got %0d IDs want >=10", seq1.size()); else nPass++;
  endtask

  // Random readies, in-order retires; run past the ID wrap.
  task automatic test_wrap();
    int cyc;
    cyc = 0;
    doReset();
    en = 1'b1;
    while ((seq0.size() < 70 || seq1.size() < 70) && cyc < 3000) begin
      @(posedge clk);
      #1;
      cyc++;
      id_out_ready[0] = ($urandom_range(0, 3) != 0);
      id_out_ready[1] = ($urandom_range(0, 3) != 0);
      id_retire = 6'(retiredCnt);
      id_retire_valid = (issuedCnt - retiredCnt >= 2) && ($urandom_range(0, 1) == 1);
      nChecks++; if (int'(outstanding) != issuedCnt - retiredCnt) $display("[TB] FAIL wrap_outstanding: got %0d want %0d", outstanding, issuedCnt - retiredCnt); else nPass++;
    end
    id_retire_valid = 1'b0;
    nChecks++; if (cyc >= 3000) $display("[TB] FAIL wrap_progress: got %0d IDs want 70", seq1.size()); else nPass++;
    if (seq0.size() >= 70 && seq1.size() >= 70) begin
      nChecks++; if (seq0[63] !== 6'd63 || seq1[63] !== 6'd63) $display("[TB] FAIL wrap_id63: got %0d/%0d want 63", seq0[63], seq1[63]); else nPass++;
      nChecks++; if (seq0[64] !== 6'd0 || seq1[64] !== 6'd0) $display("[TB] FAIL wrap_id0: got %0d/%0d want 0", seq0[64], seq1[64]); else nPass++;
    end
    nChecks++; if (sawLast == 0) $display("[TB] FAIL wrap_last_seen: got %0d want >0", sawLast); else nPass++;
    nChecks++; if (lastViol != 0) $display("[TB] FAIL wrap_last_rule: got %0d violations want 0", lastViol); else nPass++;
    nChecks++; if (retire_err !== 1'b0) $display("[TB] FAIL wrap_err: got %b want 0", retire_err); else nPass++;
    nChecks++; if (readyViol != 0) $display("[TB] FAIL wrap_retire_ready: got %0d violations want 0", readyViol); else nPass++;
    nChecks++; if (throttleViol != 0) $display("[TB] FAIL wrap_throttle: got %0d violations want 0", throttleViol); else nPass++;
  endtask

  // Full, retire one, then a same-cycle issue + retire.
  task automatic test_throttle_retire();
    doReset();
    en = 1'b1;
    id_out_ready = 2'b11;
    repeat (20) @(posedge clk);
    #1;
    nChecks++; if (int'(outstanding) != MAXO) $display("[TB] FAIL thr_full: got %0d want %0d", outstanding, MAXO); else nPass++;
    nChecks++; if (id_retire_ready !== 1'b1) $display("[TB] FAIL thr_retire_ready: got %b want 1", id_retire_ready); else nPass++;
    id_retire = 6'd0;
    id_retire_valid = 1'b1;
    @(posedge clk);
    #1;
    id_retire_valid = 1'b0;
    nChecks++; if (outstanding !== 5'd15) $display("[TB] FAIL thr_after_retire: got %0d want 15", outstanding); else nPass++;
    nChecks++; if (id_out_valid !== 2'b11) $display("[TB] FAIL thr_valid_back: got %b want 11", id_out_valid); else nPass++;
    nChecks++; if (id_out !== 6'd16) $display("[TB] FAIL thr_id16: got %0d want 16", id_out); else nPass++;
    id_retire = 6'd1;
    id_retire_valid = 1'b1;
    @(posedge clk);
    #1;
    id_retire_valid = 1'b0;
    en = 1'b0;
    nChecks++; if (outstanding !== 5'd15) $display("[TB] FAIL thr_same_cycle: got %0d want 15", outstanding); else nPass++;
    nChecks++; if (id_out !== 6'd17) $display("[TB] FAIL thr_id17: got %0d want 17", id_out); else nPass++;
    nChecks++; if (retire_err !== 1'b0) $display("[TB] FAIL thr_err: got %b want 0", retire_err); else nPass++;
  endtask

  task automatic test_retire_err();
    int n;
    int guard;
    doReset();
    en = 1'b1;
    id_out_ready = 2'b11;
    repeat (4) @(posedge clk);
    #1 en = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n = issuedCnt - retiredCnt;
    id_retire = 6'd3;
    id_retire_valid = 1'b1;
    @(posedge clk);
    #1;
    id_retire_valid = 1'b0;
    nChecks++; if (retire_err !== 1'b1) $display("[TB] FAIL err_set: got %b want 1", retire_err); else nPass++;
    nChecks++; if (int'(outstanding) != n - 1) $display("[TB] FAIL err_consumed: got %0d want %0d", outstanding, n - 1); else nPass++;
    guard = 0;
    while (issuedCnt != retiredCnt && guard < 40) begin
      id_retire = 6'(retiredCnt);
      id_retire_valid = 1'b1;
      @(posedge clk);
      #1;
      id_retire_valid = 1'b0;
      guard++;
    end
    nChecks++; if (retire_err !== 1'b1) $display("[TB] FAIL err_sticky: got %b want 1", retire_err); else nPass++;
    nChecks++; if (outstanding !== 5'd0) $display("[TB] FAIL err_drained: got %0d want 0", outstanding); else nPass++;
    id_retire_valid = 1'b1;
    #1;
    nChecks++; if (id_retire_ready !== 1'b0) $display("[TB] FAIL err_blocked_ready: got %b want 0", id_retire_ready); else nPass++;
    repeat (2) @(posedge clk);
    #1;
    id_retire_valid = 1'b0;
    nChecks++; if (outstanding !== 5'd0) $display("[TB] FAIL err_no_underflow: got %0d want 0", outstanding); else nPass++;
  endtask

  // Bring the DUT to ID 5 with ch0 accepted and ch1 pending.
  task automatic reachPartial5(output bit ok);
    int guard;
    en = 1'b1;
    id_out_ready = 2'b11;
    guard = 0;
    while (!(id_out == 6'd5 && id_out_valid == 2'b11) && guard < 40) begin
      @(posedge clk);
      #1;
      guard++;
    end
    id_out_ready = 2'b01;
    @(posedge clk);
    #1;
    ok = (guard < 40);
  endtask

  task automatic test_reset_mid_issue();
    bit ok;
    doReset();
    reachPartial5(ok);
    nChecks++; if (!ok) $display("[TB] FAIL rst_reach5: got timeout want id 5"); else nPass++;
    nChecks++; if (id_out_valid !== 2'b10 || id_out !== 6'd5) $display("[TB] FAIL rst_partial: got id %0d valid %b want 5/10", id_out, id_out_valid); else nPass++;
    sync_rst = 1'b1;
    @(posedge clk);
    #1;
    nChecks++; if (id_out !== 6'd0 || id_out_valid !== 2'b00 || outstanding !== 5'd0) $display("[TB] FAIL rst_sync_outputs: got id %0d valid %b out %0d want 0/00/0", id_out, id_out_valid, outstanding); else nPass++;
    sync_rst = 1'b0;
    clearModel();
    id_out_ready = 2'b11;
    repeat (3) @(posedge clk);
    #1;
    nChecks++; if (seq0.size() == 0 || seq1.size() == 0 || seq0[0] !== 6'd0 || seq1[0] !== 6'd0) $display("[TB] FAIL rst_sync_next_id: got %0d IDs want first ID 0", seq1.size()); else nPass++;

    reachPartial5(ok);
    @(posedge clk);
    #3 nrst = 1'b0;
    #1;
    nChecks++; if (id_out !== 6'd0 || id_out_valid !== 2'b00 || outstanding !== 5'd0 || id_out_last !== 1'b0) $display("[TB] FAIL rst_async_outputs: got id %0d valid %b out %0d want 0/00/0", id_out, id_out_valid, outstanding); else nPass++;
    @(posedge clk);
    #1 nrst = 1'b1;
    clearModel();
    id_out_ready = 2'b11;
    repeat (3) @(posedge clk);
    #1;
    nChecks++; if (seq0.size() == 0 || seq1.size() == 0 || seq0[0] !== 6'd0 || seq1[0] !== 6'd0) $display("[TB] FAIL rst_async_next_id: got %0d IDs want first ID 0", seq1.size()); else nPass++;
  endtask

  initial begin
    test_reset();
    test_full_rate();
    test_slow_channel();
    test_wrap();
    test_throttle_retire();
    test_retire_err();
    test_reset_mid_issue();
    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
